div_ctrl: RTL and testbench

- Sequencing controller between the EX stage and the shared multi-cycle divider.
- Accepts div/divu/mod/modu requests over a valid/ready handshake and holds operands stable while the divider runs.
- Fast-paths divide-by-zero and repeated operand pairs (div followed by mod on the same operands) through a one-entry result cache.
- Absorbs pipeline flushes: an in-flight division is drained, because the divider cannot be aborted.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_res_cache.sv | 40 ++++
 rtl/div_ctrl.sv | 160 ++++++++++++++++
 tb/tb_div_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared op indices, FSM encoding and constants for the divider controller
package div_pkg;

    localparam int OP_DIV  = 0;
    localparam int OP_DIVU = 1;
    localparam int OP_MOD  = 2;
    localparam int OP_MODU = 3;

    localparam logic [31:0] DIV0_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } div_state_e;

    // Signedness is part of the tag so div and divu of the same bits never alias.
    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        sgn;
    } div_tag_t;

endpackage

// File: rtl/div_res_cache.sv
// rtl/div_res_cache.sv - one-entry last-result cache holding {q,r} for one operand tag
module div_res_cache
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  div_tag_t    wr_tag_i,
    input  logic [31:0] wr_q_i,
    input  logic [31:0] wr_r_i,
    input  div_tag_t    lookup_tag_i,
    output logic        hit_o,
    output logic [31:0] hit_q_o,
    output logic [31:0] hit_r_o
);

    logic        valid_q;
    div_tag_t    tag_q;
    logic [31:0] q_q;
    logic [31:0] r_q;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
        end else if (wr_en_i) begin
            valid_q <= 1'b1;
            tag_q   <= wr_tag_i;
            q_q     <= wr_q_i;
            r_q     <= wr_r_i;
        end
    end

    assign hit_o   = valid_q && (tag_q == lookup_tag_i);
    assign hit_q_o = q_q;
    assign hit_r_o = r_q;

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - EX-stage sequencer for the shared multi-cycle divider with div0 and cache fast paths
module div_ctrl
    import div_pkg::*;
#(
    parameter bit          CACHE_EN = 1'b1,
    parameter logic [31:0] DIV0_Q   = DIV0_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_div0,
    output logic        dv_start,
    output logic        dv_signed,
    output logic [31:0] dv_x,
    output logic [31:0] dv_y,
    input  logic [31:0] dv_s,
    input  logic [31:0] dv_r,
    input  logic        dv_complete
);

    div_state_e  state_q, state_d;
    logic        rem_q, rem_d;
    logic        sgn_q, sgn_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [31:0] result_q, result_d;
    logic        div0_q, div0_d;

    logic        accept;
    logic        in_sgn;
    logic        in_rem;
    logic        in_div0;
    logic        cache_hit_raw;
    logic        cache_hit;
    logic        cache_wr;
    logic [31:0] cache_q;
    logic [31:0] cache_r;

    assign in_sgn  = in_op[OP_DIV] | in_op[OP_MOD];
    assign in_rem  = in_op[OP_MOD] | in_op[OP_MODU];
    assign in_div0 = (in_src2 == 32'd0);
    assign accept  = (state_q == ST_IDLE) && in_valid && !flush;
    assign cache_hit = CACHE_EN && cache_hit_raw;

    div_res_cache u_cache (
        .clk          (clk),
        .rst_i        (reset),
        .wr_en_i      (cache_wr),
        .wr_tag_i     ('{x: x_q, y: y_q, sgn: sgn_q}),
        .wr_q_i       (dv_s),
        .wr_r_i       (dv_r),
        .lookup_tag_i ('{x: in_src1, y: in_src2, sgn: in_sgn}),
        .hit_o        (cache_hit_raw),
        .hit_q_o      (cache_q),
        .hit_r_o      (cache_r)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (in_div0 || cache_hit) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (dv_complete) begin
                    state_d = flush ? ST_IDLE : ST_DONE;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dv_complete) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (flush || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A drained or flushed divider result still refreshes the cache.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        dv_start  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        cache_wr  = CACHE_EN && dv_start && dv_complete;
    end

    always_comb begin
        rem_d    = rem_q;
        sgn_d    = sgn_q;
        x_d      = x_q;
        y_d      = y_q;
        result_d = result_q;
        div0_d   = div0_q;
        if (accept) begin
            rem_d = in_rem;
            sgn_d = in_sgn;
            x_d   = in_src1;
            y_d   = in_src2;
            if (in_div0) begin
                result_d = in_rem ? in_src1 : DIV0_Q;
                div0_d   = 1'b1;
            end else if (cache_hit) begin
                result_d = in_rem ? cache_r : cache_q;
                div0_d   = 1'b0;
            end
        end else if ((state_q == ST_RUN) && dv_complete && !flush) begin
            result_d = rem_q ? dv_r : dv_s;
            div0_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q    <= 1'b0;
            sgn_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
            div0_q   <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            sgn_q    <= sgn_d;
            x_q      <= x_d;
            y_q      <= y_d;
            result_q <= result_d;
            div0_q   <= div0_d;
        end
    end

    assign out_result = result_q;
    assign out_div0   = div0_q;
    assign dv_signed  = sgn_q;
    assign dv_x       = x_q;
    assign dv_y       = y_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - scoreboard bench for div_ctrl with a behavioural divider and cache model
module tb_div_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_div0;
    logic        dv_start;
    logic        dv_signed;
    logic [31:0] dv_x;
    logic [31:0] dv_y;
    logic [31:0] dv_s;
    logic [31:0] dv_r;
    logic        dv_complete;

    div_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_src1     (in_src1),
        .in_src2     (in_src2),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_div0    (out_div0),
        .dv_start    (dv_start),
        .dv_signed   (dv_signed),
        .dv_x        (dv_x),
        .dv_y        (dv_y),
        .dv_s        (dv_s),
        .dv_r        (dv_r),
        .dv_complete (dv_complete)
    );

    int n_vec = 0;
    int n_fail = 0;
    int lat = 10;
    int starts = 0;
    int exp_starts = 0;
    logic [32:0] sb_q[$];

    logic [31:0] exp_x, exp_y;
    logic        exp_s;
    bit          c_v = 0;
    logic [31:0] c_x, c_y;
    bit          c_s;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y, input bit s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sx, sy;
        sx = s ? {{32{x[31]}}, x} : {32'h0, x};
        sy = s ? {{32{y[31]}}, y} : {32'h0, y};
        if (sy == 0) begin
            q = 32'hFFFF_FFFF;
            r = x;
        end else begin
            q = 32'(sx / sy);
            r = 32'(sx % sy);
        end
    endfunction

    // Behavioural divider: completes lat cycles after dv_start is seen high.
    initial begin
        int cnt;
        logic [31:0] q, r;
        cnt = 0;
        dv_complete = 0;
        dv_s = 0;
        dv_r = 0;
        forever begin
            @(posedge clk);
            #1;
            dv_complete = 0;
            if (reset || !dv_start) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == lat) begin
                    chk("dv_x_stable", dv_x, exp_x);
                    chk("dv_y_stable", dv_y, exp_y);
                    chk("dv_signed", dv_signed, exp_s);
                    ref_div(dv_x, dv_y, dv_signed, q, r);
                    dv_s = q;
                    dv_r = r;
                    dv_complete = 1;
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        logic prev;
        prev = 0;
        forever begin
            @(negedge clk);
            if (!reset && dv_start && !prev) starts++;
            prev = dv_start;
        end
    end

    // Monitor: every accepted result handshake pops one expectation.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready && !flush) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_result", out_result, e[32:1]);
                    chk("out_div0", out_div0, e[0]);
                end
            end
        end
    end

    // mode 0: normal, 1: flush 3 cycles into RUN, 2: hold in DONE then flush+out_ready, 3: reset mid-RUN
    task automatic req(input int opi, input logic [31:0] x, input logic [31:0] y, input int mode_in);
        int mode, waited, hi, bad;
        bit sgn, remsel, miss, ediv0;
        logic [31:0] q, r, er;
        mode = mode_in;
        sgn = (opi == 0) || (opi == 2);
        remsel = (opi >= 2);
        ref_div(x, y, sgn, q, r);
        ediv0 = (y == 0);
        er = ediv0 ? (remsel ? x : 32'hFFFF_FFFF) : (remsel ? r : q);
        miss = (y != 0) && !(c_v && c_x == x && c_y == y && c_s == sgn);
        if ((mode == 1 || mode == 3) && !miss) mode = 0;
        if (mode == 1 && lat < 4) lat = 4;
        if (mode == 3 && lat < 6) lat = 6;

        waited = 0;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1; waited++;
        end
        chk("in_ready_before_req", in_ready, 1);
        if (miss) begin
            exp_x = x; exp_y = y; exp_s = sgn; exp_starts++;
            c_v = 1; c_x = x; c_y = y; c_s = sgn;
        end
        in_valid = 1;
        in_op = 4'b0001 << opi;
        in_src1 = x;
        in_src2 = y;
        out_ready = (mode == 0);
        if (mode == 0) sb_q.push_back({er, ediv0});
        @(posedge clk); #1;
        in_valid = 0;
        chk("in_ready_after_accept", in_ready, 0);

        if (!miss) begin
            chk("fast_out_valid", out_valid, 1);
            chk("fast_dv_start", dv_start, 0);
        end else if (mode == 0 || mode == 2) begin
            waited = 0; hi = 0;
            while (!out_valid && waited < 100) begin
                if (dv_start) hi++;
                @(posedge clk); #1; waited++;
            end
            chk("div_latency", waited, lat);
            chk("dv_start_cycles", hi, lat);
            chk("dv_start_dropped", dv_start, 0);
        end

        case (mode)
            0: begin
                @(posedge clk); #1;
                out_ready = 0;
            end
            1: begin
                repeat (3) begin @(posedge clk); #1; end
                flush = 1;
                @(posedge clk); #1;
                flush = 0;
                waited = 0; bad = 0;
                while (!in_ready && waited < 100) begin
                    if (out_valid) bad++;
                    @(posedge clk); #1; waited++;
                end
                chk("drain_no_out_valid", bad, 0);
                chk("drain_back_to_idle", in_ready, 1);
                chk("drain_dv_start_low", dv_start, 0);
            end
            2: begin
                repeat (5) begin
                    chk("hold_out_valid", out_valid, 1);
                    chk("hold_out_result", out_result, er);
                    chk("hold_out_div0", out_div0, ediv0);
                    @(posedge clk); #1;
                end
                flush = 1;
                out_ready = 1;
                @(posedge clk); #1;
                flush = 0;
                out_ready = 0;
                chk("flush_done_idle", in_ready, 1);
                chk("flush_done_no_valid", out_valid, 0);
            end
            default: begin
                repeat (3) begin @(posedge clk); #1; end
                #2 reset = 1;
                #1;
                chk("rst_in_ready", in_ready, 1);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_result", out_result, 0);
                chk("rst_out_div0", out_div0, 0);
                chk("rst_dv_start", dv_start, 0);
                chk("rst_dv_signed", dv_signed, 0);
                chk("rst_dv_x", dv_x, 0);
                chk("rst_dv_y", dv_y, 0);
                c_v = 0;
                @(posedge clk); #1;
                reset = 0;
            end
        endcase
    endtask

    logic [31:0] xs[5];
    logic [31:0] ys[5];

    initial begin
        int mode;
        reset = 1;
        in_valid = 0;
        in_op = 0;
        in_src1 = 0;
        in_src2 = 0;
        flush = 0;
        out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_result", out_result, 0);
        chk("reset_dv_start", dv_start, 0);
        chk("reset_dv_x", dv_x, 0);
        reset = 0;
        @(posedge clk); #1;

        lat = 10; req(0, 32'd100, 32'd7, 0);
        req(2, 32'd100, 32'd7, 0);
        req(1, 32'hFFFF_FFF0, 32'd0, 0);
        req(3, 32'hFFFF_FFF0, 32'd0, 0);
        lat = 7; req(0, -32'sd20, 32'd3, 0);
        req(2, -32'sd20, 32'd3, 0);
        lat = 5; req(1, -32'sd20, 32'd3, 0);
        lat = 8; req(0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        lat = 10; req(0, 32'd1000, 32'd9, 1);
        req(2, 32'd1000, 32'd9, 0);
        lat = 4; req(1, 32'd77, 32'd5, 1);
        req(3, 32'd77, 32'd5, 0);
        lat = 6; req(1, 32'd55, 32'd5, 2);

        in_valid = 1; flush = 1; in_op = 4'b0001; in_src1 = 9; in_src2 = 3;
        @(posedge clk); #1;
        in_valid = 0; flush = 0;
        chk("flush_req_ignored_idle", in_ready, 1);
        chk("flush_req_no_valid", out_valid, 0);
        chk("flush_req_no_start", dv_start, 0);

        lat = 12; req(0, 32'd12345, 32'd11, 3);
        req(2, 32'd100, 32'd7, 0);

        xs = '{32'd100, -32'sd20, 32'h8000_0000, 32'd7, 32'd0};
        ys = '{32'd0, 32'd7, 32'hFFFF_FFFF, 32'd3, -32'sd5};
        for (int i = 0; i < 60; i++) begin
            lat = $urandom_range(1, 12);
            mode = $urandom_range(0, 9);
            mode = (mode < 6) ? 0 : (mode < 8) ? 1 : 2;
            req($urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? $urandom : xs[$urandom_range(0, 4)],
                ($urandom_range(0, 4) == 0) ? $urandom : ys[$urandom_range(0, 4)],
                mode);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 0);
        chk("divider_starts", starts, exp_starts);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
